// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP0,
    EOP1,
    EOPJ
  } state_t;

  // Line codes as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;
  localparam int unsigned ONES_W       = 3;

endpackage

// File: rtl/usb_bank_if.sv
// Register-bank side of the transmitter: CCR start/length, payload read port, STA flags.
interface usb_bank_if #(
  parameter int unsigned LEN_W = 7
);
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic [31:0]      rdaddr_o;
  logic [31:0]      rddata_i;
  logic [1:0]       sta_o;

  modport master (output start_i, len_i, rddata_i, input rdaddr_o, sta_o);
  modport slave  (input start_i, len_i, rddata_i, output rdaddr_o, sta_o);
endinterface

// File: rtl/usb_nrzi_stuffer.sv
// Bit stuffing and NRZI line encoder; stall_c flags that the next bit slot carries a stuffed 0.
module usb_nrzi_stuffer
  import usb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic bit_tick,
  input  logic tx_bit,
  input  logic se0_req,
  input  logic j_req,
  output logic dp,
  output logic dm,
  output logic stall_c
);

  logic [ONES_W-1:0] ones_q;
  logic              lvl_q;   // 1 = J
  logic [1:0]        line_q;

  assign stall_c = (ones_q == ONES_W'(STUFF_LIMIT));
  assign dp      = line_q[1];
  assign dm      = line_q[0];

  // A stuffed bit takes priority over whatever the engine offers in that slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= '0;
      lvl_q  <= 1'b1;
      line_q <= LINE_J;
    end else if (clear) begin
      ones_q <= '0;
      lvl_q  <= 1'b1;
      line_q <= LINE_J;
    end else if (bit_tick) begin
      if (stall_c || (!se0_req && !j_req && !tx_bit)) begin
        ones_q <= '0;
        lvl_q  <= ~lvl_q;
        line_q <= lvl_q ? LINE_K : LINE_J;
      end else if (se0_req) begin
        ones_q <= '0;
        lvl_q  <= 1'b1;
        line_q <= LINE_SE0;
      end else if (j_req) begin
        ones_q <= '0;
        lvl_q  <= 1'b1;
        line_q <= LINE_J;
      end else begin
        ones_q <= ones_q + ONES_W'(1);
        line_q <= lvl_q ? LINE_J : LINE_K;
      end
    end
  end

endmodule

// File: rtl/usb_tx_engine.sv
// USB full-speed packet transmitter: SYNC + payload + EOP with bit stuffing and NRZI.
module usb_tx_engine
  import usb_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned LEN_W     = 7,
  parameter int unsigned BASE_ADDR = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  usb_bank_if.slave  bank,
  output logic       dp_o,
  output logic       dm_o,
  output logic       oe_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             launch_q, launch_d;
  logic [31:0]      rdaddr_q, rdaddr_d;

  logic       bit_tick;
  logic       tick_c, tx_bit_c, se0_c, j_c, clear_c, stall_c, capture;
  logic [7:0] fetch_byte;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      len_q      <= '0;
      shreg_q    <= '0;
      div_q      <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      launch_q   <= 1'b0;
      rdaddr_q   <= 32'(BASE_ADDR);
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      shreg_q    <= shreg_d;
      div_q      <= div_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      launch_q   <= launch_d;
      rdaddr_q   <= rdaddr_d;
    end
  end

  // Next-state: each bit tick decides the symbol for the following bit time
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    shreg_d    = shreg_q;
    div_d      = '0;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = done_q;
    launch_d   = launch_q;
    tick_c     = 1'b0;
    tx_bit_c   = 1'b1;
    se0_c      = 1'b0;
    j_c        = 1'b0;
    capture    = 1'b0;
    clear_c    = (state_q == IDLE);
    fetch_byte = 8'(bank.rddata_i >> {byte_idx_q[1:0], 3'b000});
    bit_tick   = busy_q && (div_q == DIV_LAST);

    if (busy_q) div_d = bit_tick ? '0 : div_q + DIV_W'(1);

    if (state_q == IDLE) begin
      if (bank.start_i) begin
        state_d    = SYNC;
        len_d      = LEN_W'(bank.len_i);
        busy_d     = 1'b1;
        done_d     = 1'b0;
        launch_d   = 1'b1;
        div_d      = DIV_LAST;    // first tick lands on the very next edge
        bit_cnt_d  = '0;
        byte_idx_d = '0;
      end
    end else if (bit_tick) begin
      tick_c = 1'b1;
      if (launch_q) begin
        launch_d  = 1'b0;
        oe_d      = 1'b1;
        tx_bit_c  = SYNC_PATTERN[0];
        bit_cnt_d = '0;
      end else if (!stall_c) begin
        unique case (state_q)
          SYNC: begin
            if (bit_cnt_q == 3'd7) begin
              if (len_q == '0) begin
                se0_c   = 1'b1;
                state_d = EOP0;
              end else begin
                capture = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_bit_c  = SYNC_PATTERN[bit_cnt_q + 3'd1];
            end
          end
          DATA: begin
            if (bit_cnt_q == 3'd7) begin
              if (byte_idx_q == len_q) begin
                se0_c   = 1'b1;
                state_d = EOP0;
              end else begin
                capture = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_bit_c  = shreg_q[0];
              shreg_d   = shreg_q >> 1;
            end
          end
          EOP0: begin
            se0_c   = 1'b1;
            state_d = EOP1;
          end
          EOP1: begin
            j_c     = 1'b1;
            state_d = EOPJ;
          end
          default: begin
            j_c        = 1'b1;
            state_d    = IDLE;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            div_d      = '0;
            byte_idx_d = '0;
          end
        endcase
      end
    end

    // byte_idx points at the next byte to fetch, so rdaddr leads the byte on the line
    if (capture) begin
      state_d    = DATA;
      tx_bit_c   = fetch_byte[0];
      shreg_d    = {1'b0, fetch_byte[7:1]};
      byte_idx_d = byte_idx_q + LEN_W'(1);
      bit_cnt_d  = '0;
    end

    rdaddr_d = 32'(BASE_ADDR) + (32'(byte_idx_d) & ~32'd3);
  end

  usb_nrzi_stuffer u_stuffer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear    (clear_c),
    .bit_tick (tick_c),
    .tx_bit   (tx_bit_c),
    .se0_req  (se0_c),
    .j_req    (j_c),
    .dp       (dp_o),
    .dm       (dm_o),
    .stall_c  (stall_c)
  );

  assign oe_o          = oe_q;
  assign bank.sta_o    = {done_q, busy_q};
  assign bank.rdaddr_o = rdaddr_q;

endmodule
